// File: rtl/dmem_bridge.sv
// dmem_bridge -- core data-memory port to simple req/ack bus bridge.
//
// Accepts one load or store at a time from the core, holds the core with
// o_stall while the bus transaction is outstanding, and returns load data on
// o_rdata. Faults (misaligned access, simultaneous load+store, bus error,
// bus timeout) set the sticky o_err flag, which only reset clears.
//
// Optional feature: define DMEM_BRIDGE_TIMEOUT_EN to compile in an 8-bit
// wait counter that aborts a bus request after TIMEOUT cycles without a
// response. Without it, the bridge waits indefinitely for ack/err.
//
// Ports:
//   clk, rst_n                 clock; asynchronous active-low reset
//   i_addr, i_wdata            core address / store data
//   i_rd, i_wr                 core load / store strobes
//   o_rdata, o_stall           load result / core hold
//   o_bus_req, o_bus_we        bus request / write enable
//   o_bus_addr, o_bus_wdata    bus address / write data
//   i_bus_ack, i_bus_err       bus completion / error response
//   i_bus_rdata                bus read data
//   o_err                      sticky fault flag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for i_rd/i_wr; aligned -> REQ, misaligned -> DONE
// REQ   | bus request driven from holding registers until ack/err/timeout
// DONE  | single completion cycle, stall released, no new access accepted
module dmem_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [31:0] o_rdata,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata,
  output logic        o_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata_nxt;
  logic        r_we;
  logic        r_err;
  logic        w_err_set;
  logic        w_latch;
  logic        w_stall;
  logic        w_timeout;
  logic        w_access;
  logic        w_aligned;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dmem_bridge: TIMEOUT must be within 2..255");
  end

  assign w_access  = i_rd | i_wr;
  assign w_aligned = (i_addr[1:0] == 2'b00);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // Counter value k-1 during the k-th REQ cycle, so the abort decision is
  // taken in REQ cycle TIMEOUT and the request is gone the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_latch) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_REQ && !i_bus_ack && !i_bus_err) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rdata;
    w_err_set   = 1'b0;
    w_latch     = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_stall = 1'b1;
          // Load+store together resolves to the store, flagged as a fault.
          if (i_rd && i_wr) w_err_set = 1'b1;
          if (w_aligned) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_DONE;
            if (!i_wr) w_rdata_nxt = 32'h0;
          end
        end
      end
      ST_REQ: begin
        w_stall = 1'b1;
        if (i_bus_ack) begin
          // Ack wins over a coincident error; data is still taken.
          w_state_nxt = ST_DONE;
          if (!r_we)     w_rdata_nxt = i_bus_rdata;
          if (i_bus_err) w_err_set   = 1'b1;
        end else if (i_bus_err) begin
          w_state_nxt = ST_DONE;
          w_err_set   = 1'b1;
          if (!r_we) w_rdata_nxt = 32'h0;
        end else if (w_timeout) begin
          w_state_nxt = ST_DONE;
          w_err_set   = 1'b1;
          if (!r_we) w_rdata_nxt = 32'hDEADBEEF;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdata <= w_rdata_nxt;
      if (w_err_set) r_err <= 1'b1;
      if (w_latch) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
        r_we    <= i_wr;
      end
    end
  end

  // Request is decoded from state so reset removes it without a clock edge.
  assign o_bus_req   = (r_state == ST_REQ);
  assign o_bus_we    = (r_state == ST_REQ) & r_we;
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_wdata;
  assign o_rdata     = r_rdata;
  assign o_stall     = w_stall;
  assign o_err       = r_err;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge -- directed test of dmem_bridge with hand-computed values.
// Inputs change on the falling edge; checks follow 1 ns later so both
// registered and combinational outputs have settled.
// Honours DMEM_BRIDGE_TIMEOUT_EN the same way the design does.
module tb_dmem_bridge;

  localparam int TB_TIMEOUT = 4;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  // Stay one REQ cycle under the timeout so the store still completes.
  localparam int STORE_WAIT = 4;
`else
  localparam int STORE_WAIT = 5;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        i_rd;
  logic        i_wr;
  logic [31:0] o_rdata;
  logic        o_stall;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic        i_bus_err;
  logic [31:0] i_bus_rdata;
  logic        o_err;

  int n_total = 0;
  int n_pass  = 0;

  dmem_bridge #(.TIMEOUT(TB_TIMEOUT)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .i_rd        (i_rd),
    .i_wr        (i_wr),
    .o_rdata     (o_rdata),
    .o_stall     (o_stall),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .i_bus_ack   (i_bus_ack),
    .i_bus_err   (i_bus_err),
    .i_bus_rdata (i_bus_rdata),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %h required %h", tag, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; i_addr = '0; i_wdata = '0; i_rd = 1'b0; i_wr = 1'b0;
    i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
    settle();
    check("rst_req",   32'(o_bus_req), 32'd0);
    check("rst_stall", 32'(o_stall),   32'd0);
    check("rst_rdata", o_rdata,        32'h0);
    check("rst_err",   32'(o_err),     32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Load 0x100, ack in first REQ cycle.
    i_rd = 1'b1; i_addr = 32'h100;
    settle();
    check("ld_idle_stall", 32'(o_stall),   32'd1);
    check("ld_idle_req",   32'(o_bus_req), 32'd0);
    cyc();
    i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFEF00D;
    settle();
    check("ld_req",       32'(o_bus_req), 32'd1);
    check("ld_req_stall", 32'(o_stall),   32'd1);
    check("ld_addr",      o_bus_addr,     32'h100);
    check("ld_we",        32'(o_bus_we),  32'd0);
    cyc();
    i_rd = 1'b0; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    settle();
    check("ld_done_stall", 32'(o_stall),   32'd0);
    check("ld_done_req",   32'(o_bus_req), 32'd0);
    check("ld_rdata",      o_rdata,        32'hCAFEF00D);
    check("ld_err",        32'(o_err),     32'd0);
    cyc();

    // Store 0x204, response after STORE_WAIT REQ cycles.
    i_wr = 1'b1; i_addr = 32'h204; i_wdata = 32'h12345678;
    settle();
    check("st_idle_stall", 32'(o_stall), 32'd1);
    cyc();
    i_addr = 32'hFFFF_FFF0; i_wdata = 32'h0;  // core-side changes must not leak
    for (int i = 0; i < STORE_WAIT; i++) begin
      i_bus_ack = (i == STORE_WAIT - 1);
      i_bus_rdata = 32'h0BAD0BAD;
      settle();
      check($sformatf("st_req_%0d", i),   32'(o_bus_req), 32'd1);
      check($sformatf("st_we_%0d", i),    32'(o_bus_we),  32'd1);
      check($sformatf("st_addr_%0d", i),  o_bus_addr,     32'h204);
      check($sformatf("st_wdata_%0d", i), o_bus_wdata,    32'h12345678);
      cyc();
    end
    i_wr = 1'b0; i_bus_ack = 1'b0; i_bus_rdata = 32'h0;
    settle();
    check("st_done_stall", 32'(o_stall), 32'd0);
    check("st_rdata_kept", o_rdata,      32'hCAFEF00D);
    check("st_err",        32'(o_err),   32'd0);
    cyc();

    // Misaligned load 0x102: no bus request, one stall cycle.
    i_rd = 1'b1; i_addr = 32'h102;
    settle();
    check("mis_stall", 32'(o_stall),   32'd1);
    check("mis_req",   32'(o_bus_req), 32'd0);
    cyc();
    i_rd = 1'b0;
    settle();
    check("mis_done_req",   32'(o_bus_req), 32'd0);
    check("mis_done_stall", 32'(o_stall),   32'd0);
    check("mis_err",        32'(o_err),     32'd1);
    check("mis_rdata",      o_rdata,        32'h0);
    cyc();

    // Good load afterwards; o_err stays set.
    i_rd = 1'b1; i_addr = 32'h10;
    cyc();
    i_bus_ack = 1'b1; i_bus_rdata = 32'h11112222;
    cyc();
    i_rd = 1'b0; i_bus_ack = 1'b0;
    settle();
    check("ld2_rdata",  o_rdata,    32'h11112222);
    check("err_sticky", 32'(o_err), 32'd1);
    cyc();

    // Reset during REQ cycle 3.
    i_rd = 1'b1; i_addr = 32'h300;
    cyc(); cyc(); cyc();
    settle();
    check("rr_req_c3", 32'(o_bus_req), 32'd1);
    rst_n = 1'b0; i_rd = 1'b0;
    settle();
    check("rr_req",   32'(o_bus_req), 32'd0);
    check("rr_stall", 32'(o_stall),   32'd0);
    check("rr_rdata", o_rdata,        32'h0);
    check("rr_err",   32'(o_err),     32'd0);
    check("rr_addr",  o_bus_addr,     32'h0);
    check("rr_wdata", o_bus_wdata,    32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    i_rd = 1'b1; i_addr = 32'h8;
    cyc();
    i_bus_ack = 1'b1; i_bus_rdata = 32'h55AA55AA;
    settle();
    check("rr2_addr", o_bus_addr, 32'h8);
    cyc();
    i_rd = 1'b0; i_bus_ack = 1'b0;
    settle();
    check("rr2_rdata", o_rdata,    32'h55AA55AA);
    check("rr2_err",   32'(o_err), 32'd0);
    cyc();

    // Stray ack in IDLE is ignored.
    i_bus_ack = 1'b1; i_bus_rdata = 32'h00000999;
    settle();
    check("stray_stall", 32'(o_stall), 32'd0);
    cyc();
    i_bus_ack = 1'b0;
    settle();
    check("stray_rdata", o_rdata,    32'h55AA55AA);
    check("stray_err",   32'(o_err), 32'd0);

    // Load and store together at 0x40: store only, fault flagged.
    i_rd = 1'b1; i_wr = 1'b1; i_addr = 32'h40; i_wdata = 32'hA5A5A5A5;
    cyc();
    i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
    settle();
    check("rw_we",    32'(o_bus_we), 32'd1);
    check("rw_addr",  o_bus_addr,    32'h40);
    check("rw_wdata", o_bus_wdata,   32'hA5A5A5A5);
    cyc();
    i_rd = 1'b0; i_wr = 1'b0; i_bus_ack = 1'b0;
    settle();
    check("rw_err",   32'(o_err), 32'd1);
    check("rw_rdata", o_rdata,    32'h55AA55AA);
    cyc();

    // Bus error alone on a load.
    i_rd = 1'b1; i_addr = 32'h44;
    cyc();
    i_bus_err = 1'b1; i_bus_rdata = 32'h77777777;
    cyc();
    i_rd = 1'b0; i_bus_err = 1'b0;
    settle();
    check("berr_rdata", o_rdata,        32'h0);
    check("berr_req",   32'(o_bus_req), 32'd0);
    cyc();

    // Ack and error together on a load: data taken.
    i_rd = 1'b1; i_addr = 32'h48;
    cyc();
    i_bus_ack = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'h31415926;
    cyc();
    i_rd = 1'b0; i_bus_ack = 1'b0; i_bus_err = 1'b0;
    settle();
    check("ackerr_rdata", o_rdata, 32'h31415926);
    cyc();

    // Unanswered load at 0x80.
    i_rd = 1'b1; i_addr = 32'h80;
    cyc();
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      settle();
      check($sformatf("to_req_%0d", i), 32'(o_bus_req), 32'd1);
      cyc();
    end
    i_rd = 1'b0;
    settle();
    check("to_req_drop", 32'(o_bus_req), 32'd0);
    check("to_rdata",    o_rdata,        32'hDEADBEEF);
    check("to_err",      32'(o_err),     32'd1);
    cyc();
`else
    for (int i = 1; i < 50; i++) cyc();
    settle();
    check("wait50_req",   32'(o_bus_req), 32'd1);
    check("wait50_stall", 32'(o_stall),   32'd1);
    i_bus_ack = 1'b1; i_bus_rdata = 32'h600DF00D;
    cyc();
    i_rd = 1'b0; i_bus_ack = 1'b0;
    settle();
    check("wait50_rdata", o_rdata, 32'h600DF00D);
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, bus-wait cycles before abort (range 2..255).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports: i_addr  input  32 and i_wdata  input  32, core data address and store data.
REQ-005 SHALL have ports: i_rd  input  1 and i_wr  input  1, core load and store strobes.
REQ-006 SHALL have ports: o_rdata  output  32 (load result) and o_stall  output  1 (core hold).
REQ-007 SHALL have ports: o_bus_req, o_bus_we  output  1; o_bus_addr, o_bus_wdata  output  32.
REQ-008 SHALL have ports: i_bus_ack, i_bus_err  input  1; i_bus_rdata  input  32.
REQ-009 SHALL have port: o_err  output  1, sticky fault flag.

Function
REQ-010 SHALL implement FSM states IDLE, REQ, DONE.
REQ-011 IDLE, i_rd|i_wr, i_addr[1:0]==0: latch addr/wdata/we into holding registers, go REQ.
REQ-012 o_stall SHALL be combinational: 1 in IDLE when i_rd|i_wr, 1 in REQ, 0 in DONE.
REQ-013 REQ: o_bus_req=1; o_bus_addr/o_bus_wdata/o_bus_we from holding registers, stable until ack.
REQ-014 REQ, i_bus_ack=1: capture i_bus_rdata (loads only) into o_rdata, drop o_bus_req next cycle, go DONE.
REQ-015 Minimum access latency SHALL be 2 cycles stall (IDLE->REQ, ack in first REQ cycle) plus 1 DONE cycle.
REQ-016 DONE SHALL last exactly one cycle, then IDLE; no new access accepted in DONE.
REQ-017 o_rdata SHALL hold its value until the next completed load; stores SHALL NOT change it.
REQ-018 i_rd and i_wr both high in IDLE: perform store only, set o_err.
REQ-019 Misaligned access (i_addr[1:0]!=0): no bus request; set o_err; o_rdata=0 for loads; IDLE->DONE directly.
REQ-020 i_bus_ack and i_bus_err same cycle: complete as ack, also set o_err.
REQ-021 i_bus_err alone in REQ: set o_err, o_rdata=32'h0 for loads, go DONE.
REQ-022 i_bus_ack outside REQ SHALL be ignored.
REQ-023 o_err SHALL remain 1 until reset.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, o_bus_req=0, o_bus_we=0, o_stall=0 (subject to i_rd/i_wr per REQ-012 after release).
REQ-025 Reset values: o_rdata=0, o_bus_addr=0, o_bus_wdata=0, o_err=0, timeout counter=0.
REQ-026 Reset mid-REQ SHALL abandon the access; o_bus_req SHALL fall asynchronously.

Configuration
REQ-027 Macro DMEM_BRIDGE_TIMEOUT_EN SHALL compile in an 8-bit wait counter, cleared on REQ entry, incremented each REQ cycle without ack.
REQ-028 With DMEM_BRIDGE_TIMEOUT_EN: counter reaching TIMEOUT SHALL abort: o_bus_req=0, o_err=1, load o_rdata=32'hDEADBEEF, go DONE.
REQ-029 Without DMEM_BRIDGE_TIMEOUT_EN: no counter; REQ SHALL wait indefinitely for ack/err.

Verification
REQ-030 Load addr 0x100, ack 1st REQ cycle rdata 0xCAFEF00D -> o_stall 1 for 2 cycles, o_rdata=0xCAFEF00D, o_err=0.
REQ-031 Store addr 0x204 data 0x12345678, ack after 5 cycles -> o_bus_we=1, addr/data stable all 5 cycles, o_rdata unchanged.
REQ-032 Load addr 0x102 -> o_bus_req never asserts, o_err=1, o_rdata=0, one stall cycle.
REQ-033 TIMEOUT=4 with macro, no ack -> after 4 REQ cycles o_bus_req=0, o_rdata=0xDEADBEEF, o_err=1; without macro -> still stalled at cycle 50.
REQ-034 rst_n low during REQ cycle 3 -> o_bus_req 0 immediately, all outputs at reset values, next load proceeds normally.
REQ-035 i_rd=i_wr=1 addr 0x40 -> store issued (o_bus_we=1), o_err=1.
